// File: rtl/hwpe_stream_source_pkg.sv
// rtl/hwpe_stream_source_pkg.sv - state encoding and default sizing for the early-stall stream source
package hwpe_stream_source_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE,
    ABORT
  } state_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 16;
  localparam int DEF_LEN_WIDTH  = 16;
  localparam int DEF_SKID_DEPTH = 2;

endpackage

// File: rtl/hwpe_stream_source_addrgen.sv
// rtl/hwpe_stream_source_addrgen.sv - strided read address accumulator and issued-beat counter
module hwpe_stream_source_addrgen
  import hwpe_stream_source_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  i_load,
  input  logic                  i_step,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic [ADDR_WIDTH-1:0] i_stride,
  input  logic [LEN_WIDTH-1:0]  i_len,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [LEN_WIDTH-1:0]  o_len,
  output logic                  o_last
);

  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_stride;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_issued;

  // Address arithmetic wraps naturally at ADDR_WIDTH bits.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_addr   <= '0;
      r_stride <= '0;
      r_len    <= '0;
      r_issued <= '0;
    end else if (i_load) begin
      r_addr   <= i_base;
      r_stride <= i_stride;
      r_len    <= i_len;
      r_issued <= '0;
    end else if (i_step) begin
      r_addr   <= r_addr + r_stride;
      r_issued <= r_issued + LEN_WIDTH'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_len  = r_len;
  assign o_last = (r_issued == r_len);

endmodule

// File: rtl/hwpe_stream_source_earlystall.sv
// rtl/hwpe_stream_source_earlystall.sv - memory-to-FIFO producer metered by in-flight credits
module hwpe_stream_source_earlystall
  import hwpe_stream_source_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int SKID_DEPTH = DEF_SKID_DEPTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH-1:0] stride_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  push_valid_o,
  output logic [DATA_WIDTH-1:0] push_data_o,
  input  logic                  push_ready_i
);

  state_e                r_state;
  logic [LEN_WIDTH-1:0]  r_inflight;
  logic [LEN_WIDTH-1:0]  r_pushed;
  logic                  r_push_valid;
  logic [DATA_WIDTH-1:0] r_push_data;
  logic                  r_done;

  logic                  w_load;
  logic                  w_all_issued;
  logic                  w_req;
  logic                  w_grant;
  logic                  w_discard;
  logic [LEN_WIDTH-1:0]  w_len;
  logic [LEN_WIDTH-1:0]  w_credit;
  logic [LEN_WIDTH-1:0]  w_inflight_nxt;

  assign w_load = (r_state == IDLE) && start_i && !clear_i;

  hwpe_stream_source_addrgen #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .LEN_WIDTH (LEN_WIDTH)
  ) u_addrgen (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .i_load  (w_load),
    .i_step  (w_grant),
    .i_base  (base_addr_i),
    .i_stride(stride_i),
    .i_len   (len_i),
    .o_addr  (mem_addr_o),
    .o_len   (w_len),
    .o_last  (w_all_issued)
  );

  // A beat on push_valid_o this cycle has already reached the FIFO, so its credit is free now.
  assign w_credit  = r_inflight - LEN_WIDTH'(r_push_valid);
  assign w_req     = (r_state == RUN) && push_ready_i && !w_all_issued &&
                     (w_credit < LEN_WIDTH'(SKID_DEPTH));
  assign w_grant   = w_req && mem_gnt_i;
  assign w_discard = mem_rvalid_i && ((r_state == ABORT) || ((r_state == RUN) && clear_i));
  assign w_inflight_nxt = r_inflight + LEN_WIDTH'(w_grant)
                        - LEN_WIDTH'(r_push_valid) - LEN_WIDTH'(w_discard);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_inflight   <= '0;
      r_pushed     <= '0;
      r_push_valid <= 1'b0;
      r_push_data  <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_inflight   <= w_inflight_nxt;
      r_push_valid <= mem_rvalid_i && (r_state == RUN) && !clear_i;
      if (mem_rvalid_i) r_push_data <= mem_rdata_i;
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_pushed <= '0;
            if (len_i == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          if (clear_i) begin
            r_state <= ABORT;
          end else if (r_push_valid) begin
            r_pushed <= r_pushed + LEN_WIDTH'(1);
            if (r_pushed + LEN_WIDTH'(1) == w_len) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        DONE:    r_state <= clear_i ? ABORT : IDLE;
        ABORT:   if (w_inflight_nxt == '0) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy_o       = (r_state != IDLE);
  assign done_o       = r_done;
  assign mem_req_o    = w_req;
  assign push_valid_o = r_push_valid;
  assign push_data_o  = r_push_data;

endmodule

// File: tb/tb_hwpe_stream_source_earlystall.sv
// tb/tb_hwpe_stream_source_earlystall.sv - randomized scoreboard bench for the early-stall stream source
module tb_hwpe_stream_source_earlystall;
  localparam int DW   = 32;
  localparam int AW   = 16;
  localparam int LW   = 16;
  localparam int SKID = 2;

  logic          clk_i = 1'b0;
  logic          rst_i, clear_i, start_i;
  logic [AW-1:0] base_addr_i, stride_i;
  logic [LW-1:0] len_i;
  logic          busy_o, done_o, mem_req_o, mem_gnt_i, mem_rvalid_i;
  logic          push_valid_o, push_ready_i;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_rdata_i, push_data_o;

  int checks   = 0;
  int failures = 0;

  logic [15:0]   salt;
  logic          prev_grant;
  logic [AW-1:0] prev_addr;
  logic          gnt_rand, ready_rand;
  int            stall_cnt;

  always #5 clk_i = ~clk_i;

  hwpe_stream_source_earlystall dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (clear_i),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .stride_i    (stride_i),
    .len_i       (len_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .mem_req_o   (mem_req_o),
    .mem_addr_o  (mem_addr_o),
    .mem_gnt_i   (mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i (mem_rdata_i),
    .push_valid_o(push_valid_o),
    .push_data_o (push_data_o),
    .push_ready_i(push_ready_i)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a, a ^ salt};
  endfunction

  function automatic logic [AW-1:0] beat_addr(input logic [AW-1:0] b, input logic [AW-1:0] s, input int i);
    return AW'(32'(b) + 32'(s) * 32'(i));
  endfunction

  // One clock: memory answers last cycle's grant, inputs are driven, outputs are observed.
  task automatic step(input logic start, input logic clr);
    @(posedge clk_i);
    #1;
    mem_rvalid_i = prev_grant;
    mem_rdata_i  = prev_grant ? mem_word(prev_addr) : DW'($urandom);
    mem_gnt_i    = gnt_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    push_ready_i = (stall_cnt > 0) ? 1'b0 : (ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
    if (stall_cnt > 0) stall_cnt--;
    start_i = start;
    clear_i = clr;
    #1;
    prev_grant = mem_req_o && mem_gnt_i;
    prev_addr  = mem_addr_o;
  endtask

  // mode: 0 plain, 1 check back-to-back requests, 2 stall after 3rd grant, 3 clear at 3rd grant
  task automatic xfer(input logic [AW-1:0] b, input logic [AW-1:0] s, input logic [LW-1:0] n, input int mode);
    int   n_grant, n_push, n_done, inflight_m, clr_cyc;
    logic done_next, aborted, finished;
    base_addr_i = b;
    stride_i    = s;
    len_i       = n;
    salt        = 16'($urandom);
    n_grant = 0; n_push = 0; n_done = 0; inflight_m = 0; clr_cyc = -10;
    aborted = 1'b0; finished = 1'b0;
    step(1'b1, 1'b0);
    check("start_cycle_req", 32'(mem_req_o), 32'd0);
    done_next = (n == '0);
    for (int c = 1; c < 400; c++) begin
      step(1'b0, 1'b0);
      check("req_while_stalled", 32'(mem_req_o && !push_ready_i), 32'd0);
      if (done_o) n_done++;
      if (aborted) begin
        check("abort_req", 32'(mem_req_o), 32'd0);
        check("abort_push", 32'(push_valid_o), 32'd0);
        check("abort_done", 32'(done_o), 32'd0);
        if (c == clr_cyc + 2) check("abort_idle", 32'(busy_o), 32'd0);
      end else begin
        check("done_o", 32'(done_o), 32'(done_next));
        done_next = 1'b0;
        if (mem_req_o && mem_gnt_i) begin
          check("req_addr", 32'(mem_addr_o), 32'(beat_addr(b, s, n_grant)));
          if (mode == 1) check("req_cycle", 32'(c), 32'(n_grant + 1));
          n_grant++;
          inflight_m++;
          if (mode == 2 && n_grant == 3) stall_cnt = 5;
        end
        if (push_valid_o) begin
          check("push_data", push_data_o, mem_word(beat_addr(b, s, n_push)));
          n_push++;
          inflight_m--;
          if (n_push == int'(n)) done_next = 1'b1;
        end
        check("push_bound", 32'(n_push <= int'(n)), 32'd1);
        check("inflight_max", 32'(inflight_m <= SKID), 32'd1);
        if (mode == 3 && n_grant == 3) begin
          clear_i = 1'b1;
          aborted = 1'b1;
          clr_cyc = c;
        end
      end
      if (!busy_o && (aborted ? (c >= clr_cyc + 2) : (n_done > 0))) begin
        finished = 1'b1;
        break;
      end
    end
    check("xfer_finished", 32'(finished), 32'd1);
    if (aborted) begin
      check("abort_no_done", 32'(n_done), 32'd0);
      if (!gnt_rand && !ready_rand) check("abort_pushes", 32'(n_push), 32'd1);
    end else begin
      check("n_grant", 32'(n_grant), 32'(n));
      check("n_push", 32'(n_push), 32'(n));
      check("n_done", 32'(n_done), 32'd1);
    end
  endtask

  initial begin
    rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0;
    base_addr_i = '0; stride_i = '0; len_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0; push_ready_i = 1'b1;
    prev_grant = 1'b0; prev_addr = '0; stall_cnt = 0;
    gnt_rand = 1'b0; ready_rand = 1'b0; salt = '0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_req", 32'(mem_req_o), 32'd0);
    check("rst_addr", 32'(mem_addr_o), 32'd0);
    check("rst_push_valid", 32'(push_valid_o), 32'd0);
    check("rst_push_data", push_data_o, 32'd0);
    #2 rst_i = 1'b0;

    xfer(16'h0100, 16'h0004, 16'd4, 1);
    xfer(16'h0200, 16'h0010, 16'd8, 2);
    xfer(16'h0300, 16'h0004, 16'd0, 0);
    xfer(16'h0400, 16'h0008, 16'd6, 3);

    base_addr_i = 16'h0500; stride_i = 16'h0004; len_i = 16'd10; salt = 16'h5a5a;
    step(1'b1, 1'b0);
    repeat (4) step(1'b0, 1'b0);
    @(posedge clk_i);
    #3 rst_i = 1'b1;
    #1;
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_req", 32'(mem_req_o), 32'd0);
    check("midrst_addr", 32'(mem_addr_o), 32'd0);
    check("midrst_push_valid", 32'(push_valid_o), 32'd0);
    check("midrst_push_data", push_data_o, 32'd0);
    check("midrst_done", 32'(done_o), 32'd0);
    #2 rst_i = 1'b0;
    prev_grant = 1'b0;
    xfer(16'h0600, 16'h0002, 16'd5, 0);

    xfer(16'hFFFE, 16'h0004, 16'd3, 0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    check("start_clear_busy", 32'(busy_o), 32'd0);
    check("start_clear_req", 32'(mem_req_o), 32'd0);

    gnt_rand = 1'b1;
    ready_rand = 1'b1;
    for (int i = 0; i < 30; i++) begin
      xfer(AW'($urandom), AW'($urandom_range(0, 64)), LW'($urandom_range(0, 12)),
           ($urandom_range(0, 3) == 0) ? 3 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
